// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer.
package debounce_pkg;

  // Encoding keeps out == state[1] and busy == state[0], so both outputs
  // come straight from flops with no decode logic.
  typedef enum logic [1:0] {
    IDLE_LOW     = 2'b00,
    CONFIRM_HIGH = 2'b01,
    IDLE_HIGH    = 2'b10,
    CONFIRM_LOW  = 2'b11
  } deb_state_e;

  // Width of a counter that can hold 0..stable_cycles.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, confirm FSM and counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic out,
  output logic busy
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          s;
  deb_state_e    state;
  deb_state_e    state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Next state: a candidate level must be seen STABLE_CYCLES times in a row.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = CONFIRM_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CONFIRM_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt != '1) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else begin
            state_d = CONFIRM_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CONFIRM_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt != '1) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  assign out  = state[1];
  assign busy = state[0];

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel debouncer: WIDTH independent debounce_channel instances.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .out  (out[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with WIDTH=2, STABLE_CYCLES=4.
module tb_button_debouncer;
  import debounce_pkg::*;

  logic       clock;
  logic       reset;
  logic [1:0] raw;
  logic [1:0] out;
  logic [1:0] busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] raw;
    logic [1:0] out;
    logic [1:0] busy;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  button_debouncer #(
    .WIDTH(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .raw  (raw),
    .out  (out),
    .busy (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  logic [8:0] bounce;
  logic [1:0] st;

  initial begin
    // Cycle trace from idle: clean press on ch0, glitch on ch1, release on ch0.
    tbl[0]  = '{2'b01, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 2'b01};
    tbl[3]  = '{2'b01, 2'b00, 2'b01};
    tbl[4]  = '{2'b01, 2'b00, 2'b01};
    tbl[5]  = '{2'b01, 2'b01, 2'b00};
    tbl[6]  = '{2'b01, 2'b01, 2'b00};
    tbl[7]  = '{2'b11, 2'b01, 2'b00};
    tbl[8]  = '{2'b01, 2'b01, 2'b00};
    tbl[9]  = '{2'b01, 2'b01, 2'b10};
    tbl[10] = '{2'b01, 2'b01, 2'b00};
    tbl[11] = '{2'b01, 2'b01, 2'b00};
    tbl[12] = '{2'b00, 2'b01, 2'b00};
    tbl[13] = '{2'b00, 2'b01, 2'b00};
    tbl[14] = '{2'b00, 2'b01, 2'b01};
    tbl[15] = '{2'b00, 2'b01, 2'b01};
    tbl[16] = '{2'b00, 2'b01, 2'b01};
    tbl[17] = '{2'b00, 2'b00, 2'b00};
    tbl[18] = '{2'b00, 2'b00, 2'b00};

    // Reset held with raw high; outputs stay low, then rise 6 edges after release.
    reset = 1'b0;
    raw   = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_out", out, 2'b00);
      check("reset_busy", busy, 2'b00);
    end
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("post_reset_out_e%0d", e), out, (e == 6) ? 2'b11 : 2'b00);
    end

    // Return to the idle-low state.
    raw   = 2'b00;
    reset = 1'b0;
    #1;
    check("reset_async_clear", out, 2'b00);
    tick();
    reset = 1'b1;
    tick();
    check("idle_out", out, 2'b00);
    check("idle_busy", busy, 2'b00);

    // Table-driven trace.
    for (int v = 0; v < NV; v++) begin
      raw = tbl[v].raw;
      tick();
      check($sformatf("vec%0d_out", v), out, tbl[v].out);
      check($sformatf("vec%0d_busy", v), busy, tbl[v].busy);
    end

    // Bounce on ch0: out rises only after the last four 1s, 6 edges after final 0->1.
    bounce = 9'b111101101; // bit k is the value before edge k
    for (int k = 0; k <= 10; k++) begin
      raw[0] = (k <= 8) ? bounce[k] : 1'b1;
      tick();
      check($sformatf("bounce_out_e%0d", k), {1'b0, out[0]}, (k == 10) ? 2'b01 : 2'b00);
    end

    // Release, then reset during the third confirm cycle.
    raw[0] = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      check($sformatf("rel_busy_e%0d", e), busy, (e >= 2) ? 2'b01 : 2'b00);
      check($sformatf("rel_out_e%0d", e), out, 2'b01);
    end
    reset = 1'b0;
    #1;
    check("midconfirm_reset_out", out, 2'b00);
    check("midconfirm_reset_busy", busy, 2'b00);
    st = dut.gen_ch[0].u_ch.state;
    check("midconfirm_reset_state", st, IDLE_LOW);
    tick();
    tick();
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("after_reset_out_e%0d", e), out, 2'b00);
      check($sformatf("after_reset_busy_e%0d", e), busy, 2'b00);
    end

    // Both channels rise together and resolve on the same edge.
    raw = 2'b11;
    for (int e = 0; e <= 5; e++) begin
      tick();
      check($sformatf("parallel_out_e%0d", e), out, (e == 5) ? 2'b11 : 2'b00);
      check($sformatf("parallel_busy_e%0d", e), busy, (e >= 2 && e <= 4) ? 2'b11 : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
